// File: rtl/loader_pkg.sv
// Shared types for the instruction-memory loader: FSM states, the 16-bit
// instruction word, and the decode of the status outputs for each state.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE, CNT_LO, WORD_HI, WORD_LO, CHK, RUN, ERR
    } state_t;

    typedef logic [15:0] word_t;

    typedef struct packed {
        logic in_ready;
        logic cpu_rst;
        logic load_done;
        logic load_err;
    } outs_t;

    // Status outputs are registered alongside the state they belong to.
    function automatic outs_t outs_of(state_t s);
        outs_t o;
        o.in_ready  = (s != RUN) && (s != ERR);
        o.cpu_rst   = (s != RUN);
        o.load_done = (s == RUN);
        o.load_err  = (s == ERR);
        return o;
    endfunction

endpackage

// File: rtl/loader_xor_accum.sv
// 8-bit running XOR of the frame bytes, used as the frame checksum.
module loader_xor_accum
    import loader_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] acc
);

    always_ff @(posedge clk) begin
        if (clr)
            acc <= 8'h00;
        else if (en)
            acc <= acc ^ din;
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: writes framed 16-bit words into instruction
// memory and holds the CPU in reset until a frame lands. LOADER_CHECKSUM_EN adds a trailing XOR byte.
module imem_loader #(
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              do_halt,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err
);
    import loader_pkg::*;

    localparam logic [16:0] DEPTH17 = 17'(IMEM_DEPTH);

    state_t            state;
    outs_t             outs;
    logic [15:0]       count;
    logic [ADDR_W-1:0] idx;
    logic [7:0]        hi_byte;
    logic              halt_q;

    logic        xfer;
    logic        halt_rise;
    logic        last_word;
    logic [15:0] n_word;

    assign in_ready  = outs.in_ready;
    assign cpu_rst   = outs.cpu_rst;
    assign load_done = outs.load_done;
    assign load_err  = outs.load_err;

    assign xfer      = in_valid && outs.in_ready;
    assign halt_rise = do_halt && !halt_q;
    // Word count as it stands while COUNT_LO is on the bus.
    assign n_word    = {count[15:8], in_data};
    assign last_word = (17'(idx) == 17'(count) - 17'd1);

`ifdef LOADER_CHECKSUM_EN
    localparam state_t FRAME_END = CHK;
    logic [7:0] chk_acc;

    loader_xor_accum u_xor (
        .clk (CLK),
        .clr (rst || (state == RUN && halt_rise)),
        .en  (xfer && state != CHK),
        .din (in_data),
        .acc (chk_acc)
    );
`else
    localparam state_t FRAME_END = RUN;
`endif

    always_ff @(posedge CLK) begin
        if (rst) begin
            state      <= IDLE;
            outs       <= outs_of(IDLE);
            count      <= '0;
            idx        <= '0;
            hi_byte    <= '0;
            halt_q     <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            halt_q  <= do_halt;
            imem_we <= 1'b0;
            case (state)
                IDLE: if (xfer) begin
                    count[15:8] <= in_data;
                    state       <= CNT_LO;
                end
                CNT_LO: if (xfer) begin
                    count[7:0] <= in_data;
                    idx        <= '0;
                    if (17'(n_word) > DEPTH17) begin
                        state <= ERR;
                        outs  <= outs_of(ERR);
                    end else if (n_word == 16'd0) begin
                        state <= FRAME_END;
                        outs  <= outs_of(FRAME_END);
                    end else begin
                        state <= WORD_HI;
                    end
                end
                WORD_HI: if (xfer) begin
                    hi_byte <= in_data;
                    state   <= WORD_LO;
                end
                WORD_LO: if (xfer) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= idx;
                    imem_wdata <= {hi_byte, in_data};
                    idx        <= idx + 1'b1;
                    if (last_word) begin
                        state <= FRAME_END;
                        outs  <= outs_of(FRAME_END);
                    end else begin
                        state <= WORD_HI;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: if (xfer) begin
                    if (in_data == chk_acc) begin
                        state <= RUN;
                        outs  <= outs_of(RUN);
                    end else begin
                        state <= ERR;
                        outs  <= outs_of(ERR);
                    end
                end
`endif
                RUN: if (halt_rise) begin
                    state <= IDLE;
                    outs  <= outs_of(IDLE);
                    idx   <= '0;
                    count <= '0;
                end
                ERR: begin
                end
                default: begin
                    state <= IDLE;
                    outs  <= outs_of(IDLE);
                end
            endcase
        end
    end

endmodule
